// File: rtl/mips_mc_pkg.sv
// mips_mc_pkg
//   Shared definitions for the multi-cycle MIPS control path: FSM state
//   encodings, decoded opcodes, ALU/mux select encodings and fault codes.
package mips_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_I_EXEC   = 4'd10,
    S_I_WB     = 4'd11,
    S_ERROR    = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

  // States that stall on the memory handshake and are watched by the timer.
  function automatic logic is_wait_state(state_t s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// multicycle_control_if
//   Bundle between the multi-cycle controller and the datapath.
//   master : controller side (drives control strobes, reads OpCode/Zero/mem_ready)
//   slave  : datapath side (the mirror image)
interface multicycle_control_if;
  logic [5:0] OpCode;
  logic       Zero;
  logic       mem_ready;
  logic       PCEn;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       MemtoReg;
  logic       RegDst;
  logic       RegWrite;
  logic       AluSrcA;
  logic [1:0] AluSrcB;
  logic [1:0] ALUOp;
  logic [1:0] PCSource;
  logic       instr_done;
  logic       fault;
  logic [1:0] fault_code;
  logic [3:0] state;

  modport master (
    input  OpCode, Zero, mem_ready,
    output PCEn, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite,
           AluSrcA, AluSrcB, ALUOp, PCSource, instr_done, fault, fault_code, state
  );

  modport slave (
    output OpCode, Zero, mem_ready,
    input  PCEn, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite,
           AluSrcA, AluSrcB, ALUOp, PCSource, instr_done, fault, fault_code, state
  );
endinterface

// File: rtl/mc_wait_timer.sv
// mc_wait_timer
//   Counts consecutive stalled cycles (active & !mem_ready) in a memory wait
//   state and flags a timeout on the cycle where the count has reached
//   MEM_TIMEOUT-1 and memory is still not ready. MEM_TIMEOUT = 0 disables it.
// Ports:
//   clk, reset     clock, synchronous active-low reset
//   active         FSM is in a wait state
//   mem_ready      memory completes the access this cycle
//   timeout        combinational: next state must be ERROR
module mc_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic mem_ready,
  output logic timeout
);
  localparam int CW   = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam int LAST = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;

  logic [CW-1:0] cnt;
  logic          stall;
  logic          at_last;

  assign stall   = active & ~mem_ready;
  assign at_last = (cnt == CW'(LAST));
  assign timeout = (MEM_TIMEOUT != 0) && stall && at_last;

  // Any non-stalled cycle clears the count, so every wait state is entered at 0.
  always_ff @(posedge clk) begin
    if (!reset || !stall) begin
      cnt <= '0;
    end else if ((MEM_TIMEOUT != 0) && !at_last) begin
      cnt <= cnt + CW'(1);
    end
  end
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control
//   Moore-style control FSM for the multi-cycle MIPS datapath, with a memory
//   ready handshake, wait-state timeout, sticky ERROR state and a per-
//   instruction completion pulse.
// Ports:
//   clk            system clock, rising edge
//   reset          synchronous active-low reset; also forces all outputs to 0
//   bus            multicycle_control_if.master: OpCode/Zero/mem_ready in,
//                  datapath strobes, instr_done, fault, fault_code, state out
//   cycle_count,   performance counters, present only when
//   instr_count    MULTICYCLE_CONTROL_PERF_EN is defined
// Parameters: MEM_TIMEOUT (0 = wait forever), CNT_W (counter width)
module multicycle_control
  import mips_mc_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  reset,
`ifdef MULTICYCLE_CONTROL_PERF_EN
  output logic [CNT_W-1:0]      cycle_count,
  output logic [CNT_W-1:0]      instr_count,
`endif
  multicycle_control_if.master  bus
);

  state_t     state_q;
  logic [1:0] fault_code_q;
  logic       timeout;
  logic       wait_active;

  logic       pcen, iord, memread, memwrite, irwrite, memtoreg, regdst, regwrite;
  logic       alusrca, done;
  logic [1:0] alusrcb, aluop, pcsource;

  assign wait_active = is_wait_state(state_q);

  mc_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_wait_timer (
    .clk       (clk),
    .reset     (reset),
    .active    (wait_active),
    .mem_ready (bus.mem_ready),
    .timeout   (timeout)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_FETCH;
      fault_code_q <= FAULT_NONE;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (bus.mem_ready) begin
            state_q <= S_DECODE;
          end else if (timeout) begin
            state_q      <= S_ERROR;
            fault_code_q <= FAULT_TIMEOUT;
          end
        end
        S_DECODE: begin
          case (bus.OpCode)
            OP_RTYPE:     state_q <= S_R_EXEC;
            OP_LW, OP_SW: state_q <= S_MEM_ADDR;
            OP_BEQ:       state_q <= S_BRANCH;
            OP_J:         state_q <= S_JUMP;
            OP_ADDI:      state_q <= S_I_EXEC;
            default: begin
              state_q      <= S_ERROR;
              fault_code_q <= FAULT_ILLEGAL;
            end
          endcase
        end
        // IR still holds the decoded instruction, so OpCode picks load vs store.
        S_MEM_ADDR: state_q <= (bus.OpCode == OP_SW) ? S_MEM_WR : S_MEM_RD;
        S_MEM_RD, S_MEM_WR: begin
          if (bus.mem_ready) begin
            state_q <= (state_q == S_MEM_RD) ? S_MEM_WB : S_FETCH;
          end else if (timeout) begin
            state_q      <= S_ERROR;
            fault_code_q <= FAULT_TIMEOUT;
          end
        end
        S_R_EXEC: state_q <= S_R_WB;
        S_I_EXEC: state_q <= S_I_WB;
        S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP: state_q <= S_FETCH;
        S_ERROR:  state_q <= S_ERROR;
        default: begin
          state_q      <= S_ERROR;
          fault_code_q <= FAULT_ILLEGAL;
        end
      endcase
    end
  end

  always_comb begin
    pcen     = 1'b0;
    iord     = 1'b0;
    memread  = 1'b0;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    memtoreg = 1'b0;
    regdst   = 1'b0;
    regwrite = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = SRCB_B;
    aluop    = ALUOP_ADD;
    pcsource = PCSRC_ALU;
    done     = 1'b0;
    case (state_q)
      S_FETCH: begin
        memread = 1'b1;
        alusrcb = SRCB_FOUR;
        irwrite = bus.mem_ready;
        pcen    = bus.mem_ready;
      end
      S_DECODE: alusrcb = SRCB_IMMSH2;
      S_MEM_ADDR, S_I_EXEC: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
      end
      S_MEM_RD: begin
        memread = 1'b1;
        iord    = 1'b1;
      end
      S_MEM_WB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
        done     = 1'b1;
      end
      S_MEM_WR: begin
        memwrite = 1'b1;
        iord     = 1'b1;
        done     = bus.mem_ready;
      end
      S_R_EXEC: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
      end
      S_R_WB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
        done     = 1'b1;
      end
      S_I_WB: begin
        regwrite = 1'b1;
        done     = 1'b1;
      end
      S_BRANCH: begin
        alusrca  = 1'b1;
        aluop    = ALUOP_SUB;
        pcsource = PCSRC_ALUOUT;
        pcen     = bus.Zero;
        done     = 1'b1;
      end
      S_JUMP: begin
        pcsource = PCSRC_JUMP;
        pcen     = 1'b1;
        done     = 1'b1;
      end
      default: ;
    endcase
  end

  // Reset low masks every output in the same cycle, not just after the edge.
  assign bus.PCEn       = reset & pcen;
  assign bus.IorD       = reset & iord;
  assign bus.MemRead    = reset & memread;
  assign bus.MemWrite   = reset & memwrite;
  assign bus.IRWrite    = reset & irwrite;
  assign bus.MemtoReg   = reset & memtoreg;
  assign bus.RegDst     = reset & regdst;
  assign bus.RegWrite   = reset & regwrite;
  assign bus.AluSrcA    = reset & alusrca;
  assign bus.AluSrcB    = {2{reset}} & alusrcb;
  assign bus.ALUOp      = {2{reset}} & aluop;
  assign bus.PCSource   = {2{reset}} & pcsource;
  assign bus.instr_done = reset & done;
  assign bus.fault      = reset & (state_q == S_ERROR);
  assign bus.fault_code = {2{reset}} & fault_code_q;
  assign bus.state      = {4{reset}} & state_q;

`ifdef MULTICYCLE_CONTROL_PERF_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      cycle_count <= '0;
      instr_count <= '0;
    end else begin
      if (state_q != S_ERROR) cycle_count <= cycle_count + CNT_W'(1);
      if (done)               instr_count <= instr_count + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control
//   Directed stimulus with a scoreboard: each driven cycle pushes the hand-
//   derived output vector into a queue; a monitor on the falling edge pops
//   and compares it against the DUT outputs. DUT built with MEM_TIMEOUT = 4.
module tb_multicycle_control;
  import mips_mc_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  multicycle_control_if bus_if ();

`ifdef MULTICYCLE_CONTROL_PERF_EN
  logic [31:0] cycle_count, instr_count;
`endif

  multicycle_control #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
    .clk         (clk),
    .reset       (reset),
`ifdef MULTICYCLE_CONTROL_PERF_EN
    .cycle_count (cycle_count),
    .instr_count (instr_count),
`endif
    .bus         (bus_if)
  );

  always #5 clk = ~clk;

  // Vector order: {PCEn, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
  //   RegWrite, AluSrcA, AluSrcB[2], ALUOp[2], PCSource[2], instr_done,
  //   fault, fault_code[2], state[4]}
  typedef struct {
    string       name;
    logic [22:0] v;
  } exp_t;

  exp_t q[$];

  task automatic push(input string n, input logic [8:0] strb, input logic [1:0] asb,
                      input logic [1:0] aop, input logic [1:0] psrc, input logic done,
                      input logic flt, input logic [1:0] fc, input logic [3:0] st);
    exp_t e;
    e.name = n;
    e.v    = {strb, asb, aop, psrc, done, flt, fc, st};
    q.push_back(e);
  endtask

  //                      PIMMIMRRA
  task automatic e_zero(input string n);           push(n, 9'b000000000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 4'd0);  endtask
  task automatic e_fetch(input string n, input logic r);
                                                   push(n, {r, 1'b0, 1'b1, 1'b0, r, 4'b0000}, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 4'd0); endtask
  task automatic e_decode(input string n);         push(n, 9'b000000000, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 4'd1);  endtask
  task automatic e_memaddr(input string n);        push(n, 9'b000000001, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 4'd2);  endtask
  task automatic e_memrd(input string n);          push(n, 9'b011000000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 4'd3);  endtask
  task automatic e_memwb(input string n);          push(n, 9'b000001010, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 2'b00, 4'd4);  endtask
  task automatic e_memwr(input string n, input logic r);
                                                   push(n, 9'b010100000, 2'b00, 2'b00, 2'b00, r,    1'b0, 2'b00, 4'd5);  endtask
  task automatic e_rexec(input string n);          push(n, 9'b000000001, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0, 2'b00, 4'd6);  endtask
  task automatic e_rwb(input string n);            push(n, 9'b000000110, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 2'b00, 4'd7);  endtask
  task automatic e_branch(input string n, input logic z);
                                                   push(n, {z, 8'b00000001}, 2'b00, 2'b01, 2'b01, 1'b1, 1'b0, 2'b00, 4'd8); endtask
  task automatic e_jump(input string n);           push(n, 9'b100000000, 2'b00, 2'b00, 2'b10, 1'b1, 1'b0, 2'b00, 4'd9);  endtask
  task automatic e_iexec(input string n);          push(n, 9'b000000001, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 4'd10); endtask
  task automatic e_iwb(input string n);            push(n, 9'b000000010, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 2'b00, 4'd11); endtask
  task automatic e_error(input string n, input logic [1:0] fc);
                                                   push(n, 9'b000000000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, fc,    4'd15); endtask

  task automatic drive(input logic r, input logic [5:0] op, input logic z, input logic rdy);
    @(posedge clk);
    #1;
    reset            = r;
    bus_if.OpCode    = op;
    bus_if.Zero      = z;
    bus_if.mem_ready = rdy;
  endtask

  // Monitor: compare one queued expectation per falling edge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t        e;
      logic [22:0] act;
      e   = q.pop_front();
      act = {bus_if.PCEn, bus_if.IorD, bus_if.MemRead, bus_if.MemWrite, bus_if.IRWrite,
             bus_if.MemtoReg, bus_if.RegDst, bus_if.RegWrite, bus_if.AluSrcA,
             bus_if.AluSrcB, bus_if.ALUOp, bus_if.PCSource, bus_if.instr_done,
             bus_if.fault, bus_if.fault_code, bus_if.state};
      n_tests++;
      if (act !== e.v) begin
        n_fail++;
        $display("FAIL %s: got %b expected %b", e.name, act, e.v);
      end
    end
  end

  initial begin
    bus_if.OpCode    = 6'd0;
    bus_if.Zero      = 1'b0;
    bus_if.mem_ready = 1'b0;

    // Reset held low two cycles: all outputs zero.
    drive(1'b0, OP_LW, 1'b0, 1'b1); e_zero("reset0");
    drive(1'b0, OP_LW, 1'b0, 1'b1); e_zero("reset1");

    // lw, no wait states: 5 cycles.
    drive(1'b1, OP_LW, 1'b0, 1'b1); e_fetch("lw_fetch", 1'b1);
    drive(1'b1, OP_LW, 1'b0, 1'b1); e_decode("lw_decode");
    drive(1'b1, OP_LW, 1'b0, 1'b1); e_memaddr("lw_addr");
    drive(1'b1, OP_LW, 1'b0, 1'b1); e_memrd("lw_rd");
    drive(1'b1, OP_LW, 1'b0, 1'b1); e_memwb("lw_wb");

    // beq taken then not taken: 3 cycles each.
    drive(1'b1, OP_BEQ, 1'b1, 1'b1); e_fetch("beq1_fetch", 1'b1);
    drive(1'b1, OP_BEQ, 1'b1, 1'b1); e_decode("beq1_decode");
    drive(1'b1, OP_BEQ, 1'b1, 1'b1); e_branch("beq_taken", 1'b1);
    drive(1'b1, OP_BEQ, 1'b0, 1'b1); e_fetch("beq0_fetch", 1'b1);
    drive(1'b1, OP_BEQ, 1'b0, 1'b1); e_decode("beq0_decode");
    drive(1'b1, OP_BEQ, 1'b0, 1'b1); e_branch("beq_not_taken", 1'b0);

    // sw with 3 wait cycles in MEM_WR: no timeout, done only on ready.
    drive(1'b1, OP_SW, 1'b0, 1'b1); e_fetch("sw_fetch", 1'b1);
    drive(1'b1, OP_SW, 1'b0, 1'b1); e_decode("sw_decode");
    drive(1'b1, OP_SW, 1'b0, 1'b1); e_memaddr("sw_addr");
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, OP_SW, 1'b0, 1'b0); e_memwr("sw_wait", 1'b0);
    end
    drive(1'b1, OP_SW, 1'b0, 1'b1); e_memwr("sw_ready", 1'b1);

    // R-type, addi, j.
    drive(1'b1, OP_RTYPE, 1'b0, 1'b1); e_fetch("r_fetch", 1'b1);
    drive(1'b1, OP_RTYPE, 1'b0, 1'b1); e_decode("r_decode");
    drive(1'b1, OP_RTYPE, 1'b0, 1'b1); e_rexec("r_exec");
    drive(1'b1, OP_RTYPE, 1'b0, 1'b1); e_rwb("r_wb");
    drive(1'b1, OP_ADDI, 1'b0, 1'b1);  e_fetch("addi_fetch", 1'b1);
    drive(1'b1, OP_ADDI, 1'b0, 1'b1);  e_decode("addi_decode");
    drive(1'b1, OP_ADDI, 1'b0, 1'b1);  e_iexec("addi_exec");
    drive(1'b1, OP_ADDI, 1'b0, 1'b1);  e_iwb("addi_wb");
    drive(1'b1, OP_J, 1'b0, 1'b1);     e_fetch("j_fetch", 1'b1);
    drive(1'b1, OP_J, 1'b0, 1'b1);     e_decode("j_decode");
    drive(1'b1, OP_J, 1'b0, 1'b1);     e_jump("j_jump");

    // FETCH stalled: timeout after 4 cycles, ERROR is sticky.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, OP_LW, 1'b0, 1'b0); e_fetch("to_stall", 1'b0);
    end
    drive(1'b1, OP_LW, 1'b0, 1'b0); e_error("to_error", FAULT_TIMEOUT);
    drive(1'b1, OP_LW, 1'b0, 1'b1); e_error("to_hold", FAULT_TIMEOUT);
    drive(1'b0, OP_LW, 1'b0, 1'b1); e_zero("to_reset");

    // Illegal opcode, then a single-cycle reset recovers.
    drive(1'b1, 6'b111111, 1'b0, 1'b1); e_fetch("ill_fetch", 1'b1);
    drive(1'b1, 6'b111111, 1'b0, 1'b1); e_decode("ill_decode");
    drive(1'b1, 6'b111111, 1'b0, 1'b1); e_error("ill_error", FAULT_ILLEGAL);
    drive(1'b0, 6'b111111, 1'b0, 1'b1); e_zero("ill_reset");
    drive(1'b1, OP_LW, 1'b0, 1'b1);     e_fetch("post_reset_fetch", 1'b1);
`ifdef MULTICYCLE_CONTROL_PERF_EN
    #2;
    n_tests++;
    if (instr_count !== 32'd0) begin
      n_fail++;
      $display("FAIL perf_instr_count: got %0d expected 0", instr_count);
    end
`endif

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
